spi_register_master: RTL and testbench

//  - SPI initiator for the synth register interface, the other end of the spi slave inside synth.
//  - Takes {register number, value} commands on a valid/ready port and shifts each one out as a 32-bit mode-0 frame.
//  - Captures the 32 bits the slave returns on MISO; the sample readback is in bits [31:16].
//  - Used as the on-board bootstrap loader (sine table, voice params) and for loopback benches.

---
 rtl/spi_pkg.sv | 33 +++
 rtl/spi_register_master_if.sv | 28 ++
 rtl/spi_phase_timer.sv | 34 +++
 rtl/spi_register_master.sv | 149 ++++++++++++++
 tb/tb_spi_register_master.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the synth SPI register link (master and slave side).
// Contents: frame/field widths, the master FSM state type, register-number
// field constants agreed with the slave, and the frame packing helper.
package spi_pkg;

  localparam int unsigned SPI_FRAME_BITS = 32;
  localparam int unsigned SPI_ADDR_BITS  = 16;
  localparam int unsigned SPI_DATA_BITS  = 16;

  typedef enum logic [2:0] {
    IDLE,
    CS_SETUP,
    SCK_LOW,
    SCK_HIGH,
    CS_HOLD,
    CS_GAP
  } spi_master_state_t;

  // Register-number map decoded by the slave: top nibble selects the bank.
  localparam logic [SPI_ADDR_BITS-1:0] SPI_REG_BANK_MASK = 16'hF000;
  localparam logic [SPI_ADDR_BITS-1:0] SPI_REG_SINE_BASE = 16'h1000;
  localparam logic [SPI_ADDR_BITS-1:0] SPI_REG_VOICE_BASE = 16'h5000;
  localparam logic [SPI_ADDR_BITS-1:0] SPI_REG_LOOPBACK = 16'hC000;

  // Register number occupies the upper half so it is shifted out first.
  function automatic logic [SPI_FRAME_BITS-1:0] spi_frame(
    input logic [SPI_ADDR_BITS-1:0] reg_num,
    input logic [SPI_DATA_BITS-1:0] value
  );
    return {reg_num, value};
  endfunction

endpackage

// File: rtl/spi_register_master_if.sv
// Command port of spi_register_master.
//   i_CmdValid/o_CmdReady : command handshake
//   i_CmdRegister/Value   : 16-bit register number and value
//   o_Busy, o_Done        : frame in progress / one-cycle completion pulse
//   o_ReadData            : MISO word of the last completed frame
// Modport master = command issuer, slave = the SPI register master block.
interface spi_register_master_if;
  import spi_pkg::*;

  logic                      i_CmdValid;
  logic                      o_CmdReady;
  logic [SPI_ADDR_BITS-1:0]  i_CmdRegister;
  logic [SPI_DATA_BITS-1:0]  i_CmdValue;
  logic                      o_Busy;
  logic                      o_Done;
  logic [SPI_FRAME_BITS-1:0] o_ReadData;

  modport master (
    output i_CmdValid, i_CmdRegister, i_CmdValue,
    input  o_CmdReady, o_Busy, o_Done, o_ReadData
  );

  modport slave (
    input  i_CmdValid, i_CmdRegister, i_CmdValue,
    output o_CmdReady, o_Busy, o_Done, o_ReadData
  );

endinterface

// File: rtl/spi_phase_timer.sv
// Loadable down-counter timing each FSM phase.
//   i_Clock, i_Reset : clock, synchronous active-high reset
//   i_Load           : reload strobe (asserted on every state change)
//   i_LoadValue      : phase length minus one
//   o_Expire         : high in the last cycle of the phase
// Counts down to zero and holds there; never wraps.
module spi_phase_timer #(
  parameter int unsigned WIDTH = 3
) (
  input  logic             i_Clock,
  input  logic             i_Reset,
  input  logic             i_Load,
  input  logic [WIDTH-1:0] i_LoadValue,
  output logic             o_Expire
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_Load)
      cnt_d = i_LoadValue;
    else if (cnt_q != '0)
      cnt_d = cnt_q - WIDTH'(1);
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign o_Expire = (cnt_q == '0);

endmodule

// File: rtl/spi_register_master.sv
// SPI mode-0 initiator for the synth register interface.
//   i_Clock, i_Reset : clock, synchronous active-high reset
//   cmd              : command port (valid/ready, register, value, busy,
//                      done pulse, read data)
//   o_SPI_CS/SCK/MOSI: chip select (active low), SPI clock (CPOL=0), data out
//   i_SPI_MISO       : slave data in (already synchronous to i_Clock)
// Each accepted command becomes one 32-bit frame, MSB first; the 32 MISO
// bits captured on the SCK rising edges appear on o_ReadData at o_Done.
module spi_register_master
  import spi_pkg::*;
#(
  parameter int unsigned CLKS_PER_HALF_SCK = 4,
  parameter int unsigned CS_SETUP_CLKS     = 2,
  parameter int unsigned CS_HOLD_CLKS      = 2,
  parameter int unsigned CS_IDLE_CLKS      = 4
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset,
  spi_register_master_if.slave cmd,
  output logic                 o_SPI_CS,
  output logic                 o_SPI_SCK,
  output logic                 o_SPI_MOSI,
  input  logic                 i_SPI_MISO
);

  localparam int unsigned MAX_AB   = (CLKS_PER_HALF_SCK > CS_SETUP_CLKS) ? CLKS_PER_HALF_SCK : CS_SETUP_CLKS;
  localparam int unsigned MAX_CD   = (CS_HOLD_CLKS > CS_IDLE_CLKS) ? CS_HOLD_CLKS : CS_IDLE_CLKS;
  localparam int unsigned MAX_CLKS = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int unsigned PH_W     = $clog2(MAX_CLKS + 1);

  // The IDLE cycle carrying o_Done is itself a CS-high cycle, so CS_GAP
  // lasts one cycle less than the minimum gap and is skipped when that is 0.
  localparam bit              HAS_GAP  = (CS_IDLE_CLKS > 1);
  localparam logic [PH_W-1:0] LD_SETUP = PH_W'(CS_SETUP_CLKS - 1);
  localparam logic [PH_W-1:0] LD_HALF  = PH_W'(CLKS_PER_HALF_SCK - 1);
  localparam logic [PH_W-1:0] LD_HOLD  = PH_W'(CS_HOLD_CLKS - 1);
  localparam logic [PH_W-1:0] LD_GAP   = PH_W'(HAS_GAP ? CS_IDLE_CLKS - 2 : 0);
  localparam logic [5:0]      NBITS    = 6'(SPI_FRAME_BITS);

  spi_master_state_t         state_q, state_d;
  logic [SPI_FRAME_BITS-1:0] tx_q, tx_d, rx_q, rx_d, rdata_q, rdata_d;
  logic [5:0]                bits_q, bits_d;
  logic                      cs_q, cs_d, sck_q, sck_d, mosi_q, mosi_d;
  logic                      done_q, done_d, ready_q, ready_d, busy_q, busy_d;
  logic                      phase_load, phase_expire;
  logic [PH_W-1:0]           phase_val;

  spi_phase_timer #(.WIDTH(PH_W)) u_phase_timer (
    .i_Clock     (i_Clock),
    .i_Reset     (i_Reset),
    .i_Load      (phase_load),
    .i_LoadValue (phase_val),
    .o_Expire    (phase_expire)
  );

  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    bits_d  = bits_q;
    case (state_q)
      IDLE: begin
        if (cmd.i_CmdValid && ready_q) begin
          state_d = CS_SETUP;
          tx_d    = spi_frame(cmd.i_CmdRegister, cmd.i_CmdValue);
          rx_d    = '0;
          bits_d  = NBITS;
        end
      end
      CS_SETUP: if (phase_expire) state_d = SCK_LOW;
      SCK_LOW: begin
        if (phase_expire) begin
          state_d = SCK_HIGH;
          rx_d    = {rx_q[SPI_FRAME_BITS-2:0], i_SPI_MISO};
        end
      end
      SCK_HIGH: begin
        if (phase_expire) begin
          bits_d = bits_q - 6'd1;
          if (bits_q == 6'd1) begin
            state_d = CS_HOLD;
          end else begin
            state_d = SCK_LOW;
            tx_d    = {tx_q[SPI_FRAME_BITS-2:0], 1'b0};
          end
        end
      end
      CS_HOLD: if (phase_expire) state_d = HAS_GAP ? CS_GAP : IDLE;
      CS_GAP:  if (phase_expire) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Pin values are decoded from the next state so they change on the
    // same edge as the state register.
    cs_d    = (state_d == IDLE) || (state_d == CS_GAP);
    sck_d   = (state_d == SCK_HIGH);
    mosi_d  = (state_d inside {CS_SETUP, SCK_LOW, SCK_HIGH}) ? tx_d[SPI_FRAME_BITS-1] : 1'b0;
    done_d  = (state_d == IDLE) && (state_q != IDLE);
    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
    rdata_d = done_d ? rx_q : rdata_q;

    phase_load = (state_d != state_q);
    case (state_d)
      CS_SETUP:          phase_val = LD_SETUP;
      SCK_LOW, SCK_HIGH: phase_val = LD_HALF;
      CS_HOLD:           phase_val = LD_HOLD;
      CS_GAP:            phase_val = LD_GAP;
      default:           phase_val = '0;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q <= IDLE;
      tx_q    <= '0;
      rx_q    <= '0;
      rdata_q <= '0;
      bits_q  <= '0;
      cs_q    <= 1'b1;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      rdata_q <= rdata_d;
      bits_q  <= bits_d;
      cs_q    <= cs_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
      done_q  <= done_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  assign o_SPI_CS       = cs_q;
  assign o_SPI_SCK      = sck_q;
  assign o_SPI_MOSI     = mosi_q;
  assign cmd.o_CmdReady = ready_q;
  assign cmd.o_Busy     = busy_q;
  assign cmd.o_Done     = done_q;
  assign cmd.o_ReadData = rdata_q;

endmodule

// File: tb/tb_spi_register_master.sv
module tb_spi_register_master;

  localparam int H   = 2;
  localparam int LAT = 2 + 64 * H + 2 + 2;  // 134

  typedef struct {
    logic [15:0] reg_n;
    logic [15:0] val;
    logic [31:0] miso_w;
    logic [31:0] exp_frame;
    logic [31:0] exp_rd;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cs, sck, mosi;
  logic miso = 1'b0;
  logic rst_edge = 1'b1;

  spi_register_master_if bus();

  spi_register_master #(
    .CLKS_PER_HALF_SCK (2),
    .CS_SETUP_CLKS     (2),
    .CS_HOLD_CLKS      (2),
    .CS_IDLE_CLKS      (2)
  ) dut (
    .i_Clock    (clk),
    .i_Reset    (rst),
    .cmd        (bus),
    .o_SPI_CS   (cs),
    .o_SPI_SCK  (sck),
    .o_SPI_MOSI (mosi),
    .i_SPI_MISO (miso)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0;
  logic [31:0] q_miso[$], q_frame[$], q_rd[$];
  int          q_done_cyc[$];
  int exp_dones = 0, dones = 0, unexpected_done = 0, unexpected_frame = 0, rd_glitch = 0;
  int frames_started = 0, aborted = 0, abort_rises = 0, sck_cs_high = 0;
  int stab = 0, rises = 0, cs_hi_cnt = 0, last_gap = 0;
  logic p_cs = 1'b1, p_sck = 1'b0, p_mosi = 1'b0;
  logic [31:0] cap = '0, sh = '0, last_rd = '0;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_edge <= rst;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name, input int n);
    checks++;
    errors++;
    $display("FAIL %s timeout after %0d cycles", name, n);
  endtask

  // Mode-0 slave model: captures MOSI on SCK rise, shifts MISO on SCK fall.
  always @(negedge clk) begin
    if (rst_edge) begin
      if (!p_cs && cs) begin
        aborted++;
        abort_rises = rises;
      end
    end else begin
      if (p_cs && !cs) begin
        check("sck_low_at_cs_fall", {30'b0, p_sck, sck}, 32'd0);
        frames_started++;
        last_gap = cs_hi_cnt;
        rises = 0;
        cap = '0;
        if (q_miso.size() == 0) begin
          unexpected_frame++;
          sh = '0;
        end else sh = q_miso.pop_front();
        miso = sh[31];
      end
      if (!cs && !p_sck && sck) begin
        check("mosi_stable_before_rise", 32'(stab >= H), 32'd1);
        cap = {cap[30:0], mosi};
        rises++;
      end
      if (!cs && p_sck && !sck) begin
        sh = sh << 1;
        miso = sh[31];
      end
      if (cs && (sck !== p_sck)) sck_cs_high++;
      if (!p_cs && cs) begin
        check("sck_low_at_cs_rise", {30'b0, p_sck, sck}, 32'd0);
        if (rises == 32) begin
          if (q_frame.size() == 0) unexpected_frame++;
          else check("slave_frame", cap, q_frame.pop_front());
        end else begin
          aborted++;
          abort_rises = rises;
        end
      end
    end
    stab      = (mosi === p_mosi) ? stab + 1 : 1;
    cs_hi_cnt = cs ? cs_hi_cnt + 1 : 0;
    p_cs   = cs;
    p_sck  = sck;
    p_mosi = mosi;
  end

  // Done / ReadData scoreboard.
  always @(negedge clk) begin
    if (rst_edge) begin
      last_rd = bus.o_ReadData;
    end else if (bus.o_Done) begin
      dones++;
      if (q_done_cyc.size() == 0) unexpected_done++;
      else begin
        check("done_cycle", 32'(cyc), 32'(q_done_cyc.pop_front()));
        check("read_data", bus.o_ReadData, q_rd.pop_front());
      end
      last_rd = bus.o_ReadData;
    end else if (bus.o_ReadData !== last_rd) begin
      rd_glitch++;
      last_rd = bus.o_ReadData;
    end
  end

  task automatic send_cmd(input logic [15:0] r, input logic [15:0] v, input logic [31:0] miso_w,
                          input logic [31:0] exp_frame, input logic [31:0] exp_rd,
                          input bit keep, input bit exp_done, output int t0);
    int n = 0;
    @(negedge clk);
    bus.i_CmdValid    = 1'b1;
    bus.i_CmdRegister = r;
    bus.i_CmdValue    = v;
    while (!bus.o_CmdReady && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) timeout("accept", n);
    t0 = cyc;
    q_miso.push_back(miso_w);
    if (exp_done) begin
      q_frame.push_back(exp_frame);
      q_rd.push_back(exp_rd);
      q_done_cyc.push_back(cyc + LAT);
      exp_dones++;
    end
    @(negedge clk);
    check("cs_after_accept", 32'(cs), 32'd0);
    check("mosi_after_accept", 32'(mosi), 32'(exp_frame[31]));
    check("ready_after_accept", 32'(bus.o_CmdReady), 32'd0);
    check("busy_after_accept", 32'(bus.o_Busy), 32'd1);
    if (!keep) bus.i_CmdValid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((q_done_cyc.size() != 0 || !bus.o_CmdReady) && n < 1000);
    if (n >= 1000) timeout("wait_idle", n);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[0:4];
    int t0, t0b, n, f0, d0;
    vecs[0] = '{16'h5012, 16'h00F0, 32'hA5A53C3C, 32'h501200F0, 32'hA5A53C3C};
    vecs[1] = '{16'h0001, 16'hFFFF, 32'h00000000, 32'h0001FFFF, 32'h00000000};
    vecs[2] = '{16'hFFFF, 16'h0000, 32'hFFFFFFFF, 32'hFFFF0000, 32'hFFFFFFFF};
    vecs[3] = '{16'h8000, 16'h0001, 32'h80000001, 32'h80000001, 32'h80000001};
    vecs[4] = '{16'h1234, 16'hABCD, 32'h13579BDF, 32'h1234ABCD, 32'h13579BDF};

    bus.i_CmdValid    = 1'b0;
    bus.i_CmdRegister = '0;
    bus.i_CmdValue    = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_cs", 32'(cs), 32'd1);
    check("reset_sck", 32'(sck), 32'd0);
    check("reset_mosi", 32'(mosi), 32'd0);
    check("reset_done", 32'(bus.o_Done), 32'd0);
    check("reset_busy", 32'(bus.o_Busy), 32'd0);
    check("reset_ready", 32'(bus.o_CmdReady), 32'd0);
    check("reset_readdata", bus.o_ReadData, 32'd0);
    rst = 1'b0;
    n = 0;
    while (!bus.o_CmdReady && n < 3) begin
      @(negedge clk);
      n++;
    end
    check("ready_after_reset", 32'(bus.o_CmdReady), 32'd1);

    for (int i = 0; i < 5; i++) begin
      send_cmd(vecs[i].reg_n, vecs[i].val, vecs[i].miso_w, vecs[i].exp_frame, vecs[i].exp_rd, 1'b0, 1'b1, t0);
      wait_idle();
    end

    // Back-to-back with valid held high.
    send_cmd(16'h1003, 16'h7E81, 32'h3C3CA5A5, 32'h10037E81, 32'h3C3CA5A5, 1'b1, 1'b1, t0);
    send_cmd(16'h5AA5, 16'h0FF0, 32'h55AA00FF, 32'h5AA50FF0, 32'h55AA00FF, 1'b0, 1'b1, t0b);
    check("b2b_accept_in_done_cycle", 32'(t0b), 32'(t0 + LAT));
    wait_idle();
    check("b2b_cs_high_gap", 32'(last_gap), 32'd2);

    // Valid pulsed while busy must be ignored.
    f0 = frames_started;
    d0 = dones;
    send_cmd(16'h2222, 16'h3333, 32'hDEADBEEF, 32'h22223333, 32'hDEADBEEF, 1'b0, 1'b1, t0);
    repeat (9) @(negedge clk);
    bus.i_CmdValid    = 1'b1;
    bus.i_CmdRegister = 16'h6666;
    bus.i_CmdValue    = 16'h7777;
    check("busy_cycle_index", 32'(cyc), 32'(t0 + 10));
    check("ready_while_busy", 32'(bus.o_CmdReady), 32'd0);
    @(negedge clk);
    bus.i_CmdValid = 1'b0;
    wait_idle();
    repeat (20) @(negedge clk);
    check("busy_pulse_frames", 32'(frames_started - f0), 32'd1);
    check("busy_pulse_dones", 32'(dones - d0), 32'd1);

    // Reset after the 17th SCK rise aborts the frame.
    send_cmd(16'h7777, 16'h1111, 32'h12345678, 32'h77771111, 32'h0, 1'b0, 1'b0, t0);
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (rises < 17 && n < 400);
    if (n >= 400) timeout("wait_17th_rise", n);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_cs", 32'(cs), 32'd1);
    check("abort_sck", 32'(sck), 32'd0);
    check("abort_mosi", 32'(mosi), 32'd0);
    check("abort_done", 32'(bus.o_Done), 32'd0);
    check("abort_readdata", bus.o_ReadData, 32'd0);
    n = 0;
    while (!bus.o_CmdReady && n < 2) begin
      @(negedge clk);
      n++;
    end
    check("abort_ready", 32'(bus.o_CmdReady), 32'd1);
    send_cmd(16'hC001, 16'h0123, 32'h0F0F5AA5, 32'hC0010123, 32'h0F0F5AA5, 1'b0, 1'b1, t0);
    wait_idle();
    repeat (5) @(negedge clk);
    check("abort_count", 32'(aborted), 32'd1);
    check("abort_rise_count", 32'(abort_rises), 32'd17);

    check("done_count", 32'(dones), 32'(exp_dones));
    check("done_count_abs", 32'(dones), 32'd9);
    check("unexpected_done", 32'(unexpected_done), 32'd0);
    check("unexpected_frame", 32'(unexpected_frame), 32'd0);
    check("frames_pending", 32'(q_frame.size()), 32'd0);
    check("sck_edge_cs_high", 32'(sck_cs_high), 32'd0);
    check("readdata_changed_without_done", 32'(rd_glitch), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
